// File: rtl/domino_prefix_sum_stage.sv
// Kogge-Stone carry network and sum stage fed by the domino SPG row.
// Operands are captured at the end of the evaluate phase, then pass through a two-stage prefix pipeline.
module domino_prefix_sum_stage #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [W-1:0] G,
  input  logic [W-1:0] P,
  input  logic         Sub,
  input  logic         IN_VALID,
  output logic         IN_READY,
  output logic [W-1:0] SUM,
  output logic         COUT,
  output logic         OVF,
  output logic         OUT_VALID,
  input  logic         OUT_READY
);

  // Handshake: a transfer happens on an edge where valid and ready are both high.
  // Valid never drops and data never changes until that edge.
  localparam int L  = $clog2(W + 1);
  localparam int L1 = (L + 1) / 2;

  // One Kogge-Stone level at distance d. Position 0 is bit -1; position j is bit j-1.
  function automatic logic [2*W+1:0] ks_level(input logic [W:0] g, input logic [W:0] p, input int d);
    logic [W:0] gn;
    logic [W:0] pn;
    gn = g;
    pn = p;
    for (int j = d; j <= W; j++) begin
      gn[j] = g[j] | (p[j] & g[j-d]);
      pn[j] = p[j] & p[j-d];
    end
    return {gn, pn};
  endfunction

  logic         s0_set_q, s0_clr_q;
  logic [W-1:0] s0_g_q, s0_p_q;
  logic         s0_sub_q;
  logic         s0_v;

  logic         s1_v_q;
  logic [W:0]   s1_g_q, s1_pp_q;
  logic [W-1:0] s1_p_q;
  logic [W:0]   s1_g_d, s1_pp_d;

  logic         out_v_q, cout_q, ovf_q;
  logic [W-1:0] sum_q;
  logic [W:0]   g2, p2;
  logic [W-1:0] sum_d;
  logic         cout_d, ovf_d;

  logic         s1_load, s2_load;

  // s0_v is owned by two clock edges: the falling edge toggles set, the rising edge toggles clear.
  assign s0_v     = s0_set_q ^ s0_clr_q;
  assign IN_READY = !s0_v;
  assign s2_load  = s1_v_q && (!out_v_q || OUT_READY);
  assign s1_load  = s0_v && (!s1_v_q || s2_load);

  always_ff @(negedge CLK or posedge RST) begin
    if (RST) begin
      s0_set_q <= 1'b0;
      s0_g_q   <= '0;
      s0_p_q   <= '0;
      s0_sub_q <= 1'b0;
    end else if (IN_VALID && IN_READY) begin
      s0_set_q <= ~s0_set_q;
      s0_g_q   <= G;
      s0_p_q   <= P;
      s0_sub_q <= Sub;
    end
  end

  always_comb begin
    s1_g_d  = {s0_g_q, s0_sub_q};
    s1_pp_d = {s0_p_q, 1'b0};
    for (int k = 0; k < L1; k++) begin
      {s1_g_d, s1_pp_d} = ks_level(s1_g_d, s1_pp_d, 1 << k);
    end
  end

  always_comb begin
    g2 = s1_g_q;
    p2 = s1_pp_q;
    for (int k = L1; k < L; k++) begin
      {g2, p2} = ks_level(g2, p2, 1 << k);
    end
    // g2[j] is now C[j-1]; g2[0] is the carry-in Sub.
    sum_d  = s1_p_q ^ g2[W-1:0];
    cout_d = g2[W];
    ovf_d  = g2[W] ^ g2[W-1];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s0_clr_q <= 1'b0;
      s1_v_q   <= 1'b0;
      s1_g_q   <= '0;
      s1_pp_q  <= '0;
      s1_p_q   <= '0;
      out_v_q  <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (s1_load) begin
        s0_clr_q <= ~s0_clr_q;
        s1_g_q   <= s1_g_d;
        s1_pp_q  <= s1_pp_d;
        s1_p_q   <= s0_p_q;
        s1_v_q   <= 1'b1;
      end else if (s2_load) begin
        s1_v_q   <= 1'b0;
      end
      if (s2_load) begin
        sum_q   <= sum_d;
        cout_q  <= cout_d;
        ovf_q   <= ovf_d;
        out_v_q <= 1'b1;
      end else if (out_v_q && OUT_READY) begin
        out_v_q <= 1'b0;
      end
    end
  end

  assign SUM       = sum_q;
  assign COUT      = cout_q;
  assign OVF       = ovf_q;
  assign OUT_VALID = out_v_q;

endmodule

// File: tb/tb_domino_prefix_sum_stage.sv
// Bench for domino_prefix_sum_stage: directed vectors, streaming, back-pressure, reset flush and random traffic.
module tb_domino_prefix_sum_stage;
  localparam int W  = 16;
  localparam int CW = W + 2;

  logic         CLK = 1'b0;
  logic         RST;
  logic [W-1:0] G, P;
  logic         Sub, IN_VALID, OUT_READY;
  logic         IN_READY, COUT, OVF, OUT_VALID;
  logic [W-1:0] SUM;

  int checks = 0;
  int errors = 0;
  logic [CW-1:0] exp_q[$];
  logic rand_ready = 1'b0;
  int run_len = 0;
  int max_run = 0;

  domino_prefix_sum_stage #(.W(W)) dut (
    .CLK(CLK), .RST(RST), .G(G), .P(P), .Sub(Sub), .IN_VALID(IN_VALID),
    .IN_READY(IN_READY), .SUM(SUM), .COUT(COUT), .OVF(OVF),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  // Reference: plain integer addition of A and (B or ~B) plus Sub; overflow from the two top carries.
  function automatic logic [CW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    logic [W-1:0] bx;
    logic [W:0]   full;
    logic [W-1:0] low;
    bx   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, sub};
    low  = {1'b0, a[W-2:0]} + {1'b0, bx[W-2:0]} + {{(W-1){1'b0}}, sub};
    return {full[W] ^ low[W-1], full[W], full[W-1:0]};
  endfunction

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    logic done;
    done = 1'b0;
    for (int t = 0; t < 60 && !done; t++) begin
      @(posedge CLK); #1;
      G = a & (b ^ {W{sub}});
      P = a ^ b ^ {W{sub}};
      Sub = sub;
      IN_VALID = 1'b1;
      if (IN_READY) begin
        exp_q.push_back(model(a, b, sub));
        done = 1'b1;
      end
      @(negedge CLK); #1;
      G = '1;
      P = '1;
      IN_VALID = 1'b0;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: actual not_accepted required accepted");
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || OUT_VALID) && t < 100) begin
      @(negedge CLK); #1;
      t++;
    end
    check("drain_empty", CW'(exp_q.size()), CW'(0));
  endtask

  initial begin
    forever begin
      @(posedge CLK); #1;
      if (rand_ready) OUT_READY = ($urandom_range(0, 3) != 0);
    end
  end

  // Scoreboard compare on every falling edge, where outputs are stable.
  initial begin
    logic hold_v;
    logic [CW-1:0] held;
    logic [CW-1:0] e;
    hold_v = 1'b0;
    held = '0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        hold_v = 1'b0;
        run_len = 0;
      end else begin
        if (hold_v) begin
          check("hold_valid", CW'(OUT_VALID), CW'(1));
          check("hold_data", {OVF, COUT, SUM}, held);
        end
        hold_v = 1'b0;
        if (OUT_VALID) run_len++; else run_len = 0;
        if (run_len > max_run) max_run = run_len;
        if (OUT_VALID && OUT_READY) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: actual %h required none", {OVF, COUT, SUM});
          end else begin
            e = exp_q.pop_front();
            check("result", {OVF, COUT, SUM}, e);
          end
        end else if (OUT_VALID) begin
          hold_v = 1'b1;
          held = {OVF, COUT, SUM};
        end
      end
    end
  end

  initial begin
    RST = 1'b1;
    IN_VALID = 1'b0;
    G = '1;
    P = '1;
    Sub = 1'b0;
    OUT_READY = 1'b1;
    #1;
    check("rst_in_ready", CW'(IN_READY), CW'(1));
    check("rst_out_valid", CW'(OUT_VALID), CW'(0));
    check("rst_outputs", {OVF, COUT, SUM}, CW'(0));
    repeat (2) @(posedge CLK);
    #2 RST = 1'b0;

    check("model_pin_ovf", model(16'h7FFF, 16'h0001, 1'b0), {2'b10, 16'h8000});
    check("model_pin_sub", model(16'h0005, 16'h0003, 1'b1), {2'b01, 16'h0002});
    check("model_pin_wrap", model(16'hFFFF, 16'h0001, 1'b0), {2'b01, 16'h0000});

    // Latency: valid at the second rising edge after capture.
    send(16'h7FFF, 16'h0001, 1'b0);
    @(negedge CLK);
    check("latency_early", CW'(OUT_VALID), CW'(0));
    @(negedge CLK);
    check("latency_valid", CW'(OUT_VALID), CW'(1));
    check("direct_ovf", {OVF, COUT, SUM}, {2'b10, 16'h8000});
    send(16'h0005, 16'h0003, 1'b1);
    send(16'hFFFF, 16'h0001, 1'b0);
    drain();

    max_run = 0;
    for (int i = 0; i < 8; i++) send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
    drain();
    check("stream_run", CW'(max_run), CW'(8));

    fork
      begin
        for (int i = 0; i < 8; i++) send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
      end
      begin
        repeat (3) @(posedge CLK);
        #2 OUT_READY = 1'b0;
        repeat (5) @(posedge CLK);
        #2;
        check("bp_in_ready", CW'(IN_READY), CW'(0));
        check("bp_in_flight", CW'(exp_q.size()), CW'(3));
        OUT_READY = 1'b1;
      end
    join
    drain();

    send(W'($urandom), W'($urandom), 1'b0);
    @(posedge CLK);
    #2 RST = 1'b1;
    @(negedge CLK); #1;
    check("flush_in_ready", CW'(IN_READY), CW'(1));
    check("flush_out_valid", CW'(OUT_VALID), CW'(0));
    check("flush_sum", CW'(SUM), CW'(0));
    exp_q.delete();
    RST = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      check("flush_no_emit", CW'(OUT_VALID), CW'(0));
    end
    send(16'h1234, 16'h0F0F, 1'b0);
    drain();

    rand_ready = 1'b1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) @(posedge CLK);
      send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
    end
    rand_ready = 1'b0;
    @(posedge CLK);
    #2 OUT_READY = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
